uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared UART definitions: FSM state encoding and frame
//               constants (line levels, data width, bit timer width). Also
//               intended for the companion receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Frame phases; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic START_LEVEL = 1'b0;  // start bit drives the line low
  localparam logic STOP_LEVEL  = 1'b1;  // stop bits and idle are high
  localparam int   DATA_BITS   = 8;     // 8N1 / 8N2 framing, no parity
  localparam int   CNT_W       = 16;    // bit timer covers up to 65535 clocks

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8 data bits LSB first, no parity,
//               STOP_BITS stop bits. A single-cycle 'transmit' in IDLE
//               latches tx_byte and starts a frame; requests while busy are
//               dropped.
// Ports       : clk             - system clock, rising edge
//               rst             - synchronous active-high reset
//               tx_byte[7:0]    - byte to send, sampled on the accept edge
//               transmit        - send request
//               is_transmitting - high while a frame is in progress
//               tx              - registered serial line, idle high
//               tx_done         - one-cycle pulse at end of final stop bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,  // 2..65535
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       is_transmitting,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       C_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       C_STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;
  logic             w_bit_end;

  // Last clock of the current bit period
  assign w_bit_end = (cnt_q == C_BIT_LAST);

  // --------------------------------------------------------------------------
  // State / datapath register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= STOP_LEVEL;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (transmit) state_d = ST_START;
      ST_START: if (w_bit_end) state_d = ST_DATA;
      ST_DATA:  if (w_bit_end && (bit_idx_q == C_DATA_LAST)) state_d = ST_STOP;
      ST_STOP:  if (w_bit_end && (bit_idx_q == C_STOP_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic. tx_d is the level for the *next* cycle, so the
  // line changes exactly on the edge that begins each bit period.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d     = w_bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        tx_d      = STOP_LEVEL;
        if (transmit) begin
          shift_d = tx_byte;
          tx_d    = START_LEVEL;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (bit_idx_q == C_DATA_LAST) begin
            // Index restarts to count stop bits; never reaches a ninth data bit
            bit_idx_d = '0;
            tx_d      = STOP_LEVEL;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      ST_STOP: begin
        tx_d = STOP_LEVEL;
        if (w_bit_end) begin
          if (bit_idx_q == C_STOP_LAST) begin
            bit_idx_d = '0;
            tx_done_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        tx_d      = STOP_LEVEL;
      end
    endcase
  end

  assign tx              = tx_q;
  assign tx_done         = tx_done_q;
  assign is_transmitting = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. dut1 runs CLKS_PER_BIT=4,
//               STOP_BITS=1; dut2 runs CLKS_PER_BIT=3, STOP_BITS=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte1, tx_byte2;
  logic       transmit1, transmit2;
  logic       busy1, busy2, tx1, tx2, done1, done2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte1), .transmit(transmit1),
    .is_transmitting(busy1), .tx(tx1), .tx_done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte2), .transmit(transmit2),
    .is_transmitting(busy2), .tx(tx2), .tx_done(done2)
  );

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit i = line level during bit period i
    int          g1;      // cycle of a stray transmit pulse, -1 = none
    int          g2;
    logic [7:0]  gbyte;
  } vec_t;

  vec_t vecs[5];

  // {tx, is_transmitting, tx_done}
  function automatic logic [2:0] obs(int sel);
    return (sel == 0) ? {tx1, busy1, done1} : {tx2, busy2, done2};
  endfunction

  // Reference frame straight from the framing rules
  function automatic logic [10:0] model_frame(logic [7:0] d);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      f[i] = 1'b0;
      else if (i <= 8) f[i] = d[i-1];
      else             f[i] = 1'b1;
    end
    return f;
  endfunction

  task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got tx/busy/done=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive(int sel, logic t, logic [7:0] b);
    if (sel == 0) begin transmit1 = t; tx_byte1 = b; end
    else          begin transmit2 = t; tx_byte2 = b; end
  endtask

  task automatic start(int sel, logic [7:0] d);
    @(negedge clk);
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1 drive(sel, 1'b0, ~d);
  endtask

  // Check every cycle from the one after acceptance to the tx_done cycle.
  // k = 0 is the first cycle after the accept edge.
  task automatic watch(int sel, string tag, logic [10:0] frame, int g1, int g2,
                       logic [7:0] gbyte, bit chain, logic [7:0] chain_byte);
    int c = (sel == 0) ? 4 : 3;
    int s = (sel == 0) ? 1 : 2;
    int l = (9 + s) * c;
    logic [2:0] exp;
    for (int k = 0; k <= l; k++) begin
      @(negedge clk);
      exp = (k < l) ? {frame[k / c], 2'b10} : 3'b101;
      chk($sformatf("%s k=%0d", tag, k), obs(sel), exp);
      if (k == l && chain)
        drive(sel, 1'b1, chain_byte);
      else if (k == g1 || k == g2)
        drive(sel, 1'b1, gbyte);
      else
        drive(sel, 1'b0, 8'($urandom));
    end
    if (chain) begin
      @(posedge clk);
      #1 drive(sel, 1'b0, ~chain_byte);
    end else begin
      drive(sel, 1'b0, 8'h00);
      @(negedge clk);
      chk({tag, " after"}, obs(sel), 3'b100);
    end
  endtask

  initial begin
    logic [7:0] d, nb;
    bit         ch, prev_ch;

    vecs[0] = '{8'h55, 11'b11010101010, -1, -1, 8'h00};
    vecs[1] = '{8'hA3, 11'b11101000110,  5, 30, 8'hFF};
    vecs[2] = '{8'h3C, 11'b11001111000,  0,  1, 8'h00};
    vecs[3] = '{8'hFF, 11'b11111111110, 39, -1, 8'h00};
    vecs[4] = '{8'h00, 11'b11000000000, -1, -1, 8'hFF};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset dut1", obs(0), 3'b100);
    chk("reset dut2", obs(1), 3'b100);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle1 %0d", i), obs(0), 3'b100);
      chk($sformatf("idle2 %0d", i), obs(1), 3'b100);
    end

    // Reset wins over a simultaneous request
    rst = 1'b1;
    drive(0, 1'b1, 8'h5A);
    @(negedge clk);
    chk("rst+transmit", obs(0), 3'b100);
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("rst+transmit after", obs(0), 3'b100);

    // Table-driven frames on dut1, with stray requests mid-frame
    for (int v = 0; v < 5; v++) begin
      start(0, vecs[v].data);
      watch(0, $sformatf("vec%0d", v), vecs[v].frame, vecs[v].g1, vecs[v].g2,
            vecs[v].gbyte, 1'b0, 8'h00);
    end

    // Back-to-back: 0x00 then 0xFF in the first idle cycle
    start(0, 8'h00);
    watch(0, "b2b0", 11'b11000000000, -1, -1, 8'h00, 1'b1, 8'hFF);
    watch(0, "b2b1", 11'b11111111110, -1, -1, 8'h00, 1'b0, 8'h00);

    // Mid-frame reset at cycle 14 of a 0x0F frame
    start(0, 8'h0F);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("abort k=%0d", k), obs(0), {vecs[0].frame[0] & 1'b0 | 11'b11000011110 >> (k / 4) & 1'b1, 2'b10});
      if (k == 14) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort reset", obs(0), 3'b100);
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk($sformatf("abort idle %0d", i), obs(0), 3'b100);
    end
    start(0, 8'h81);
    watch(0, "post-abort", 11'b11100000010, -1, -1, 8'h00, 1'b0, 8'h00);

    // Two stop bits, 3 clocks per bit
    start(1, 8'h3C);
    watch(1, "8n2", 11'b11001111000, 7, 32, 8'hC3, 1'b0, 8'h00);

    // Randomized frames against the reference model, some chained
    prev_ch = 1'b0;
    d = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      if (!prev_ch) start(0, d);
      ch = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      nb = 8'($urandom);
      watch(0, $sformatf("rnd%0d", i), model_frame(d), $urandom_range(0, 39),
            -1, 8'($urandom), ch, nb);
      prev_ch = ch;
      d = nb;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
